vdec_hs_sched: RTL and testbench
================================

# vdec_hs_sched

Job scheduler that shares the single HS-SCCH/AGCH Viterbi decoder between three requesters: HS-SCCH part1, HS-SCCH part2 and AGCH. It queues one pending request per requester and issues jobs with fixed priority. For each job it drives the decoder start/mode handshake, supervises completion with a watchdog, and returns a per-requester completion or timeout pulse with the CRC result. It sits between the slot/channel timing logic and the decoder controller.

## Interface
- TIMEOUT, 4096: max WAIT cycles before a job is aborted; legal range 2..65535
- CNT_W, 16: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT
- clk  in  1  system clock, 307.2 MHz
- rst_n  in  1  asynchronous active-low reset
- req  in  3  single-cycle request strobes; bit0 part1, bit1 part2, bit2 agch
- pending  out  3  registered pending flags, one per requester
- req_ovf  out  3  one-cycle pulse: a strobe hit a bit that was already pending
- dec_start  out  1  one-cycle decoder start pulse
- dec_mode  out  2  decoder mode: 2'b00 part1, 2'b01 part2, 2'b10 agch
- dec_abort  out  1  one-cycle decoder abort pulse, issued on timeout
- dec_done  in  1  decoder completion pulse
- dec_crc_match  in  1  CRC result, valid while dec_done is high
- ack  out  3  one-hot completion pulse for the granted requester
- tmo  out  3  one-hot timeout pulse for the granted requester
- res_match  out  1  CRC result of the last completed job; held until the next completion
- busy  out  1  high in every state except IDLE
- fsm_out  out  2  current state, for debug

## Operation
- State encoding: IDLE=0, WAIT=1, DONE=2, ABORT=3.
- Pending set/clear:
  - pending[i] is set on an edge where req[i]=1.
  - pending[i] is cleared on the edge where requester i is granted.
  - If req[i] arrives on the grant edge, the request wins and pending[i] stays 1.
  - If req[i] arrives while pending[i]=1 and no grant occurs on that edge, the request is dropped and req_ovf[i] pulses for one cycle.
- IDLE: if pending≠0, grant the highest-priority pending bit (part1 > part2 > agch). On that edge:
  - latch job_id;
  - drive dec_mode;
  - set dec_start=1 for one cycle;
  - clear the watchdog counter to 0;
  - go to WAIT.
- WAIT: the counter increments each cycle.
  - If dec_done=1: latch res_match and go to DONE. For part1, res_match is forced to 1 because part1 carries no CRC.
  - Otherwise, if counter == TIMEOUT-1: go to ABORT.
  - If dec_done and the timeout coincide, dec_done wins.
- DONE: ack[job_id]=1 for this cycle only; go to IDLE.
- ABORT: tmo[job_id]=1 and dec_abort=1 for this cycle only; res_match is unchanged; go to IDLE.
- dec_done outside WAIT is ignored.
- dec_mode holds its value from grant until the next grant.
- Reset values: all outputs 0; pending=0; state IDLE; dec_mode=2'b00; counter 0.
- Reset mid-job: everything returns to reset values immediately and pending requests are discarded. dec_abort is not issued; the decoder is reset by the same rst_n.

## Timing
- Request to start: req[i] strobe at edge E0 → pending[i]=1 after E0 → dec_start high after E1 (one cycle of latency after pending, when idle).
- Completion: dec_done sampled high at edge D → ack and res_match valid after D (1 cycle).
- Back-to-back jobs: DONE → IDLE → grant, so the next dec_start occurs 2 cycles after the ack cycle.
- Timeout: the abort takes effect on the TIMEOUT-th WAIT cycle after dec_start; tmo and dec_abort are high in the following cycle.
- All outputs are registered or decoded directly from the state/registers. No combinational path from inputs to outputs.

## Test plan
- Single agch job: req=3'b100 at cycle 0; dec_done with dec_crc_match=1 ten cycles after dec_start → dec_mode=2'b10, dec_start at cycle 2, ack=3'b100 for one cycle, res_match=1, busy low again afterwards.
- Priority: req=3'b111 in one cycle → jobs issued in the order part1, part2, agch.
  - Each job is started only after the previous ack.
  - pending sequence: 111 → 110 → 100 → 000.
  - part1 res_match=1 even with dec_crc_match=0.
- Overflow and grant collision:
  - req[1] twice while a part1 job is in WAIT → req_ovf=3'b010 pulse; only one part2 job runs.
  - req[2] on the agch grant edge → pending[2] remains 1 and a second agch job follows.
- Timeout with TIMEOUT=8 and no dec_done → tmo[job] and dec_abort pulse 8 cycles after dec_start; no ack; res_match unchanged.
- Coincident dec_done and timeout on cycle TIMEOUT-1 → ack, no tmo, no dec_abort.
- rst_n asserted mid-WAIT with pending=3'b110 → outputs 0 and pending 0 immediately; no job starts after release until a new req arrives.

Source files
------------

// File: rtl/vdec_hs_sched.sv
// vdec_hs_sched: shares the single HS-SCCH/AGCH Viterbi decoder between
// HS-SCCH part1, HS-SCCH part2 and AGCH. One pending request is held per
// requester; jobs are issued with fixed priority part1 > part2 > agch, each
// supervised by a watchdog, and answered with a one-hot ack or tmo pulse.
//
// Decoder handshake: dec_start is a one-cycle pulse issued together with a
// new dec_mode value; the decoder answers with a one-cycle dec_done pulse
// carrying dec_crc_match. dec_done is only honoured while a job is in WAIT.
// A job that sees no dec_done within TIMEOUT WAIT cycles is aborted with a
// one-cycle dec_abort pulse.
module vdec_hs_sched #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] pending,
    output logic [2:0] req_ovf,
    output logic       dec_start,
    output logic [1:0] dec_mode,
    output logic       dec_abort,
    input  logic       dec_done,
    input  logic       dec_crc_match,
    output logic [2:0] ack,
    output logic [2:0] tmo,
    output logic       res_match,
    output logic       busy,
    output logic [1:0] fsm_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       pend_q;
    logic [2:0]       ovf_q;
    logic [2:0]       grant;
    logic [1:0]       job_q, job_d;
    logic [1:0]       mode_q;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q;
    logic             res_q;

    // Next-state logic: priority grant in IDLE, done/watchdog decision in WAIT
    always_comb begin
        state_d = state_q;
        grant   = 3'b000;
        job_d   = job_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q != 3'b000) begin
                    if (pend_q[0]) begin
                        grant = 3'b001;
                        job_d = 2'd0;
                    end else if (pend_q[1]) begin
                        grant = 3'b010;
                        job_d = 2'd1;
                    end else begin
                        grant = 3'b100;
                        job_d = 2'd2;
                    end
                    start_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // a completion arriving on the last watchdog cycle still counts
                if (dec_done) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ABORT;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, job and decoder-handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            job_q   <= 2'd0;
            mode_q  <= 2'b00;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            start_q <= start_d;
            if (start_d) begin
                mode_q <= job_d;
            end
        end
    end

    // Pending flags: a strobe on the grant edge re-arms the bit it clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 3'b000;
            ovf_q  <= 3'b000;
        end else begin
            pend_q <= (pend_q & ~grant) | req;
            ovf_q  <= req & pend_q & ~grant;
        end
    end

    // Watchdog counter, cleared on grant and advanced while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start_d) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // CRC result capture; part1 has no CRC so it always reports a match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= 1'b0;
        end else if (state_q == WAIT && dec_done) begin
            res_q <= (job_q == 2'd0) ? 1'b1 : dec_crc_match;
        end
    end

    assign pending   = pend_q;
    assign req_ovf   = ovf_q;
    assign dec_start = start_q;
    assign dec_mode  = mode_q;
    assign dec_abort = (state_q == ABORT);
    assign ack       = (state_q == DONE)  ? (3'b001 << job_q) : 3'b000;
    assign tmo       = (state_q == ABORT) ? (3'b001 << job_q) : 3'b000;
    assign res_match = res_q;
    assign busy      = (state_q != IDLE);
    assign fsm_out   = state_q;

endmodule

// File: tb/tb_vdec_hs_sched.sv
// Bench for vdec_hs_sched. A driver issues request strobes and plays the
// decoder; a timestamp-based reference model predicts grants, completion
// cycles and pending flags, pushing expected events into a queue that a
// separate monitor pops whenever the DUT presents an output event.
module tb_vdec_hs_sched;

  localparam int T = 8;
  localparam int W = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] req = 3'b000;
  logic       dec_done = 1'b0;
  logic       dec_crc_match = 1'b0;
  logic [2:0] pending, req_ovf, ack, tmo;
  logic       dec_start, dec_abort, res_match, busy;
  logic [1:0] dec_mode, fsm_out;

  vdec_hs_sched #(.TIMEOUT(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pending(pending), .req_ovf(req_ovf),
    .dec_start(dec_start), .dec_mode(dec_mode), .dec_abort(dec_abort),
    .dec_done(dec_done), .dec_crc_match(dec_crc_match), .ack(ack), .tmo(tmo),
    .res_match(res_match), .busy(busy), .fsm_out(fsm_out)
  );

  // scoreboard: event = {kind(0 start,1 ack,2 tmo), id, match, pad, cycle}
  logic [W-1:0] exp_q[$];
  logic [34:0]  ovf_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [2:0] m_pend = 3'b000;
  logic       m_res = 1'b0;
  logic [1:0] m_mode = 2'b00;
  logic       m_has_job = 1'b0;
  logic       m_completes = 1'b0;
  logic       m_crc = 1'b0;
  int         m_job = 0;
  int         m_g = -10;
  int         m_resolve = -10;
  int         m_done_at = -1;
  int         force_lat = -1;
  int         force_crc = -1;
  logic [2:0] exp_pend = 3'b000;
  logic       exp_res = 1'b0;
  logic [1:0] exp_mode = 2'b00;
  logic       exp_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pending"}, 32'(pending), 0);
    check({tag, "_req_ovf"}, 32'(req_ovf), 0);
    check({tag, "_dec_start"}, 32'(dec_start), 0);
    check({tag, "_dec_mode"}, 32'(dec_mode), 0);
    check({tag, "_dec_abort"}, 32'(dec_abort), 0);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_tmo"}, 32'(tmo), 0);
    check({tag, "_res_match"}, 32'(res_match), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_fsm"}, 32'(fsm_out), 0);
  endtask

  // driver + model for the coming rising edge e
  task automatic step_body(input logic [2:0] r);
    int e, lat, id;
    logic [2:0] g, ovf;
    logic d, crc, was_idle;
    e = cyc + 1;
    d = (e == m_done_at);
    // stray completions only where the scheduler is not waiting on a job
    if (!d && !(m_has_job && e > m_g && e <= m_resolve) && $urandom_range(0, 7) == 0) d = 1'b1;
    dec_done = d;
    dec_crc_match = (e == m_done_at) ? m_crc : 1'($urandom_range(0, 1));
    was_idle = !m_has_job;
    g = 3'b000;
    id = 0;
    if (was_idle && m_pend != 3'b000) begin
      for (int i = 2; i >= 0; i--) if (m_pend[i]) id = i;
      g = 3'b001 << id;
    end
    ovf = r & m_pend & ~g;
    m_pend = (m_pend & ~g) | r;
    if (m_has_job && e == m_resolve && m_completes) m_res = (m_job == 0) ? 1'b1 : m_crc;
    if (m_has_job && e == m_resolve + 1) m_has_job = 1'b0;
    if (g != 3'b000) begin
      lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, T + 2));
      crc = (force_crc >= 0) ? 1'(force_crc) : 1'($urandom_range(0, 1));
      m_job = id;
      m_mode = 2'(id);
      m_g = e;
      m_has_job = 1'b1;
      m_completes = (lat <= T);
      m_resolve = e + (m_completes ? lat : T);
      m_done_at = e + lat;
      m_crc = crc;
      exp_q.push_back({2'd0, 2'(id), 1'b0, 3'b000, 32'(e)});
      exp_q.push_back({(m_completes ? 2'd1 : 2'd2), 2'(id), ((id == 0) ? 1'b1 : crc), 3'b000, 32'(m_resolve)});
    end
    if (ovf != 3'b000) ovf_q.push_back({ovf, 32'(e)});
    exp_pend = m_pend;
    exp_res = m_res;
    exp_mode = m_mode;
    exp_busy = m_has_job;
    req = r;
  endtask

  task automatic step(input logic [2:0] r);
    @(negedge clk);
    #1;
    step_body(r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_has_job || m_pend != 3'b000) && n < 500) begin
      step(3'b000);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: model still busy after %0d cycles", n);
    end
  endtask

  task automatic model_clear();
    m_pend = 3'b000; m_res = 1'b0; m_mode = 2'b00; m_has_job = 1'b0;
    m_done_at = -1; m_g = -10; m_resolve = -10;
    exp_q.delete();
    ovf_q.delete();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req = 3'b000;
    dec_done = 1'b0;
    #1;
    check_zero("midreset");
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    step_body(3'b000);
  endtask

  // monitor: per-cycle state checks plus event pops from the scoreboard
  initial begin
    logic [W-1:0] ev;
    logic [2:0] oh, exp_ovf;
    int now, ev_cyc, kind;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        now = cyc;
        check("pending", 32'(pending), 32'(exp_pend));
        check("busy", 32'(busy), 32'(exp_busy));
        check("res_match", 32'(res_match), 32'(exp_res));
        check("dec_mode", 32'(dec_mode), 32'(exp_mode));
        exp_ovf = 3'b000;
        if (ovf_q.size() > 0 && int'(ovf_q[0][31:0]) == now) exp_ovf = ovf_q.pop_front()[34:32];
        if (req_ovf != 3'b000 || exp_ovf != 3'b000) check("req_ovf", 32'(req_ovf), 32'(exp_ovf));
        if (dec_start || ack != 3'b000 || tmo != 3'b000 || dec_abort) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: start=%0b ack=%b tmo=%b abort=%0b required none (cycle %0d)",
                     dec_start, ack, tmo, dec_abort, now);
          end else begin
            ev = exp_q.pop_front();
            kind = int'(ev[39:38]);
            ev_cyc = int'(ev[31:0]);
            oh = 3'b001 << ev[37:36];
            check("event_cycle", 32'(now), 32'(ev_cyc));
            case (kind)
              0: begin
                check("start_pulse", {dec_start, ack, tmo, dec_abort}, {1'b1, 3'b000, 3'b000, 1'b0});
                check("start_mode", 32'(dec_mode), 32'(ev[37:36]));
                check("start_fsm", 32'(fsm_out), 1);
              end
              1: begin
                check("ack_pulse", {dec_start, ack, tmo, dec_abort}, {1'b0, oh, 3'b000, 1'b0});
                check("ack_res", 32'(res_match), 32'(ev[35]));
                check("ack_fsm", 32'(fsm_out), 2);
              end
              default: begin
                check("tmo_pulse", {dec_start, ack, tmo, dec_abort}, {1'b0, 3'b000, oh, 1'b1});
                check("tmo_fsm", 32'(fsm_out), 3);
              end
            endcase
          end
        end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) <= now) begin
          ev = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_event: kind %0d id %0d due cycle %0d, got no output (cycle %0d)",
                   ev[39:38], ev[37:36], ev[31:0], now);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  // stimulus sequence
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    // single agch job, completion ten cycles after start
    force_lat = 10; force_crc = 1;
    step_body(3'b100);
    wait_idle();
    // priority order with failing CRC: part1 still reports a match
    force_lat = 5; force_crc = 0;
    step(3'b111);
    wait_idle();
    // overflow: second part2 strobe while part2 already pending
    force_lat = 10; force_crc = 1;
    step(3'b001);
    step(3'b000);
    step(3'b010);
    step(3'b010);
    wait_idle();
    // agch strobe on its own grant edge re-arms the request
    force_lat = 3;
    step(3'b100);
    step(3'b100);
    wait_idle();
    // watchdog timeout (late completion is ignored), then coincident done
    force_lat = T + 1;
    step(3'b010);
    wait_idle();
    force_lat = T + 2;
    step(3'b100);
    wait_idle();
    force_lat = T; force_crc = 0;
    step(3'b100);
    wait_idle();
    force_lat = 1; force_crc = 1;
    step(3'b010);
    wait_idle();
    // reset in WAIT with two requests pending
    force_lat = 10;
    step(3'b001);
    step(3'b000);
    step(3'b110);
    step(3'b000);
    step(3'b000);
    @(negedge clk);
    check("pre_reset_pending", 32'(pending), 32'b110);
    reset_mid();
    repeat (10) step(3'b000);
    // randomized traffic
    force_lat = -1; force_crc = -1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
    end
    wait_idle();
    repeat (4) step(3'b000);
    check("drain_exp_q", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
